// File: rtl/gmsk_burst_receive_if.sv
// rtl/gmsk_burst_receive_if.sv - sample-in / bit-out bundle for the GMSK burst receiver
interface gmsk_burst_receive_if;
    logic              sample_strobe;
    logic signed [7:0] in_i;
    logic signed [7:0] in_q;
    logic              iq_valid;
    logic              arm;
    logic              is_armed;
    logic              rx_bit;
    logic              rx_bit_valid;
    logic              sync_found;
    logic              burst_done;
    logic              burst_abort;

    modport master (
        output sample_strobe, in_i, in_q, iq_valid, arm,
        input  is_armed, rx_bit, rx_bit_valid, sync_found, burst_done, burst_abort
    );

    modport slave (
        input  sample_strobe, in_i, in_q, iq_valid, arm,
        output is_armed, rx_bit, rx_bit_valid, sync_found, burst_done, burst_abort
    );
endinterface

// File: rtl/gmsk_burst_receive.sv
// rtl/gmsk_burst_receive.sv - GMSK burst receiver: phase discriminator, sync hunt, payload bits
module gmsk_burst_receive #(
    parameter int          OSR          = 4,
    parameter int          SYNC_LEN     = 26,
    parameter logic [31:0] SYNC_WORD    = 32'h0970897,
    parameter int          SYNC_TOL     = 2,
    parameter int          HUNT_MAX     = 64,
    parameter int          PAYLOAD_BITS = 116
) (
    input logic                 clock,
    input logic                 reset_n,
    gmsk_burst_receive_if.slave bus
);
    localparam int PH_W    = $clog2(OSR);
    localparam int ACC_W   = 17 + PH_W;
    localparam int CTR_MAX = (HUNT_MAX > PAYLOAD_BITS) ? HUNT_MAX : PAYLOAD_BITS;
    localparam int CTR_W   = $clog2(CTR_MAX + 1);
    localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HUNT, S_PAYLOAD, S_DONE} state_t;

    state_t                   state_q,   state_d;
    logic signed [7:0]        prev_i_q,  prev_i_d;
    logic signed [7:0]        prev_q_q,  prev_q_d;
    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic [PH_W-1:0]          phase_q,   phase_d;
    logic                     iv_prev_q, iv_prev_d;
    logic [SYNC_LEN-1:0]      shreg_q,   shreg_d;
    logic [CTR_W-1:0]         bit_ctr_q, bit_ctr_d;
    logic                     rx_bit_q,       rx_bit_d;
    logic                     rx_bit_valid_q, rx_bit_valid_d;
    logic                     sync_found_q,   sync_found_d;
    logic                     burst_done_q,   burst_done_d;
    logic                     burst_abort_q,  burst_abort_d;

    logic                     strobe_v;
    logic                     strobe_drop;
    logic                     burst_start;
    logic signed [7:0]        op_i, op_q;
    logic signed [15:0]       prod_a, prod_b;
    logic signed [16:0]       d_term;
    logic signed [ACC_W-1:0]  acc_base, acc_sum;
    logic [PH_W-1:0]          ph_base;
    logic                     closing;
    logic                     dec_bit;

    assign strobe_v    = bus.sample_strobe & bus.iq_valid;
    assign strobe_drop = bus.sample_strobe & ~bus.iq_valid;
    // Only a low-to-high envelope transition seen on strobes starts a burst
    assign burst_start = (state_q == S_ARMED) && strobe_v && !iv_prev_q;

    // The first sample of a burst sees a zeroed history, so its cross term is 0
    assign op_i     = burst_start ? 8'sd0 : prev_i_q;
    assign op_q     = burst_start ? 8'sd0 : prev_q_q;
    assign acc_base = burst_start ? '0 : acc_q;
    assign ph_base  = burst_start ? '0 : phase_q;

    assign prod_a   = 16'(op_i) * 16'(bus.in_q);
    assign prod_b   = 16'(op_q) * 16'(bus.in_i);
    assign d_term   = 17'(prod_a) - 17'(prod_b);
    assign acc_sum  = acc_base + ACC_W'(d_term);
    assign closing  = strobe_v && (ph_base == PH_W'(OSR - 1));
    // Net clockwise rotation over the symbol decodes as 1
    assign dec_bit  = acc_sum[ACC_W-1];

    assign bus.is_armed     = (state_q == S_ARMED);
    assign bus.rx_bit       = rx_bit_q;
    assign bus.rx_bit_valid = rx_bit_valid_q;
    assign bus.sync_found   = sync_found_q;
    assign bus.burst_done   = burst_done_q;
    assign bus.burst_abort  = burst_abort_q;

    always_comb begin
        state_d        = state_q;
        prev_i_d       = prev_i_q;
        prev_q_d       = prev_q_q;
        acc_d          = acc_q;
        phase_d        = phase_q;
        iv_prev_d      = iv_prev_q;
        shreg_d        = shreg_q;
        bit_ctr_d      = bit_ctr_q;
        rx_bit_d       = rx_bit_q;
        rx_bit_valid_d = 1'b0;
        sync_found_d   = 1'b0;
        burst_done_d   = 1'b0;
        burst_abort_d  = 1'b0;

        if (bus.sample_strobe) begin
            iv_prev_d = bus.iq_valid;
        end
        if (strobe_v) begin
            prev_i_d = bus.in_i;
            prev_q_d = bus.in_q;
            acc_d    = closing ? '0 : acc_sum;
            phase_d  = closing ? '0 : ph_base + PH_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.arm) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (burst_start) begin
                    state_d   = S_HUNT;
                    shreg_d   = '0;
                    bit_ctr_d = '0;
                end
            end
            S_HUNT: begin
                if (strobe_drop) begin
                    burst_abort_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (closing) begin
                    shreg_d   = {shreg_q[SYNC_LEN-2:0], dec_bit};
                    bit_ctr_d = bit_ctr_q + CTR_W'(1);
                    if (bit_ctr_d >= CTR_W'(SYNC_LEN) &&
                        $countones(shreg_d ^ SYNC_PAT) <= SYNC_TOL) begin
                        sync_found_d = 1'b1;
                        bit_ctr_d    = '0;
                        state_d      = S_PAYLOAD;
                    end else if (bit_ctr_d == CTR_W'(HUNT_MAX)) begin
                        burst_abort_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (strobe_drop) begin
                    burst_abort_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (closing) begin
                    rx_bit_d       = dec_bit;
                    rx_bit_valid_d = 1'b1;
                    bit_ctr_d      = bit_ctr_q + CTR_W'(1);
                    if (bit_ctr_d == CTR_W'(PAYLOAD_BITS)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                burst_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            prev_i_q       <= '0;
            prev_q_q       <= '0;
            acc_q          <= '0;
            phase_q        <= '0;
            iv_prev_q      <= 1'b0;
            shreg_q        <= '0;
            bit_ctr_q      <= '0;
            rx_bit_q       <= 1'b0;
            rx_bit_valid_q <= 1'b0;
            sync_found_q   <= 1'b0;
            burst_done_q   <= 1'b0;
            burst_abort_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_i_q       <= prev_i_d;
            prev_q_q       <= prev_q_d;
            acc_q          <= acc_d;
            phase_q        <= phase_d;
            iv_prev_q      <= iv_prev_d;
            shreg_q        <= shreg_d;
            bit_ctr_q      <= bit_ctr_d;
            rx_bit_q       <= rx_bit_d;
            rx_bit_valid_q <= rx_bit_valid_d;
            sync_found_q   <= sync_found_d;
            burst_done_q   <= burst_done_d;
            burst_abort_q  <= burst_abort_d;
        end
    end
endmodule

// File: tb/tb_gmsk_burst_receive.sv
// tb/tb_gmsk_burst_receive.sv - scoreboard bench for gmsk_burst_receive
module tb_gmsk_burst_receive;
    localparam logic [25:0] SYNC = 26'h0970897;
    localparam int K_SYNC = 0, K_BIT = 1, K_DONE = 2, K_ABORT = 3;
    localparam int NB = 142;

    typedef struct {
        int   kind;
        logic bitv;
        int   at;
    } ev_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   closed = 0;
    logic tx_bits [0:NB-1];
    ev_t  q[$];

    gmsk_burst_receive_if bus();
    gmsk_burst_receive dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return {26'b0, bus.is_armed, bus.rx_bit, bus.rx_bit_valid,
                bus.sync_found, bus.burst_done, bus.burst_abort};
    endfunction

    // 16-point circle, amplitude 100, 22.5 degrees per step
    function automatic logic signed [7:0] cos16(input int k);
        int m;
        m = ((k % 16) + 16) % 16;
        case (m)
            0: return 8'sd100;   1: return 8'sd92;    2: return 8'sd71;    3: return 8'sd38;
            4: return 8'sd0;     5: return -8'sd38;   6: return -8'sd71;   7: return -8'sd92;
            8: return -8'sd100;  9: return -8'sd92;   10: return -8'sd71;  11: return -8'sd38;
            12: return 8'sd0;    13: return 8'sd38;   14: return 8'sd71;   default: return 8'sd92;
        endcase
    endfunction

    // Full-scale square constellation, counterclockwise with increasing index
    function automatic logic signed [7:0] corner_i(input int k);
        int m;
        m = ((k % 4) + 4) % 4;
        return (m == 1 || m == 2) ? 8'sd127 : -8'sd128;
    endfunction

    function automatic logic signed [7:0] corner_q(input int k);
        int m;
        m = ((k % 4) + 4) % 4;
        return (m >= 2) ? 8'sd127 : -8'sd128;
    endfunction

    always @(negedge clock) begin
        int  np;
        int  kind;
        ev_t e;
        if (reset_n) begin
            np = int'(bus.sync_found) + int'(bus.rx_bit_valid) +
                 int'(bus.burst_done) + int'(bus.burst_abort);
            if (np > 1) check("pulse_exclusive", np, 1);
            if (np == 1) begin
                kind = bus.sync_found ? K_SYNC : bus.rx_bit_valid ? K_BIT :
                       bus.burst_done ? K_DONE : K_ABORT;
                if (q.size() == 0) begin
                    check("unexpected_pulse", kind, -1);
                end else begin
                    e = q.pop_front();
                    check("ev_kind", kind, e.kind);
                    check("ev_bitcount", closed, e.at);
                    if (kind == K_BIT) check("rx_bit", int'(bus.rx_bit), int'(e.bitv));
                end
            end
        end
    end

    task automatic push(input int kind, input logic b, input int at);
        ev_t e;
        e.kind = kind; e.bitv = b; e.at = at;
        q.push_back(e);
    endtask

    task automatic expect_burst(input int nb, input int drop);
        int lim, st, cnt;
        logic [25:0] sh;
        lim = (drop >= 0) ? drop : nb;
        st = 1; cnt = 0; sh = '0;
        for (int k = 1; k <= lim; k++) begin
            if (st == 1) begin
                sh = {sh[24:0], tx_bits[k-1]};
                cnt++;
                if (cnt >= 26 && $countones(sh ^ SYNC) <= 2) begin
                    push(K_SYNC, 1'b0, k); st = 2; cnt = 0;
                end else if (cnt == 64) begin
                    push(K_ABORT, 1'b0, k); st = 0;
                end
            end else if (st == 2) begin
                push(K_BIT, tx_bits[k-1], k);
                cnt++;
                if (cnt == 116) begin
                    push(K_DONE, 1'b0, k); st = 0;
                end
            end
        end
        if (drop >= 0 && st != 0) push(K_ABORT, 1'b0, drop);
    endtask

    task automatic load_bits(input int f0, input int f1, input int f2);
        logic [25:0] sw;
        sw = SYNC;
        for (int i = 0; i < 26; i++) tx_bits[i] = sw[25-i];
        for (int i = 26; i < NB; i++) tx_bits[i] = 1'($urandom);
        if (f0 >= 0) tx_bits[f0] = ~tx_bits[f0];
        if (f1 >= 0) tx_bits[f1] = ~tx_bits[f1];
        if (f2 >= 0) tx_bits[f2] = ~tx_bits[f2];
    endtask

    task automatic send(input logic signed [7:0] si, input logic signed [7:0] sq,
                        input logic v, input logic cl);
        bus.in_i = si; bus.in_q = sq; bus.iq_valid = v; bus.sample_strobe = 1'b1;
        @(posedge clock); #1;
        bus.sample_strobe = 1'b0;
        if (cl) closed++;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        @(posedge clock); #1;
        bus.arm = 1'b0;
    endtask

    task automatic run_burst(input int nb, input int drop, input bit corner, input bit rst_mid);
        int p;
        logic signed [7:0] si, sq;
        closed = 0; p = 0;
        send(8'sd0, 8'sd0, 1'b0, 1'b0);
        send(8'sd0, 8'sd0, 1'b0, 1'b0);
        for (int n = 0; n < nb * 4; n++) begin
            if (drop >= 0 && n == drop * 4) begin
                send(8'sd0, 8'sd0, 1'b0, 1'b0);
                break;
            end
            if (n > 0) p = tx_bits[n/4] ? p - 1 : p + 1;
            si = corner ? corner_i(p) : cos16(p);
            sq = corner ? corner_q(p) : cos16(p - 4);
            if (rst_mid && n == nb * 4 - 1) begin
                bus.in_i = si; bus.in_q = sq; bus.iq_valid = 1'b1; bus.sample_strobe = 1'b1;
                @(posedge clock); #1;
                bus.sample_strobe = 1'b0;
                closed++;
                check("pre_reset_valid", int'(bus.rx_bit_valid), 1);
                reset_n = 1'b0;
                #1;
                check("async_reset_outs", outs(), 0);
                bus.iq_valid = 1'b0;
                @(negedge clock); @(negedge clock);
                reset_n = 1'b1;
                @(posedge clock); #1;
                return;
            end
            send(si, sq, 1'b1, (n % 4) == 3);
        end
        send(8'sd0, 8'sd0, 1'b0, 1'b0);
        send(8'sd0, 8'sd0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.sample_strobe = 1'b0; bus.in_i = '0; bus.in_q = '0;
        bus.iq_valid = 1'b0; bus.arm = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            bus.sample_strobe = 1'($urandom); bus.iq_valid = 1'($urandom);
            bus.arm = 1'($urandom);
            bus.in_i = 8'($urandom); bus.in_q = 8'($urandom);
            @(negedge clock);
            check("reset_outs", outs(), 0);
        end
        bus.sample_strobe = 1'b0; bus.iq_valid = 1'b0; bus.arm = 1'b0;
        bus.in_i = '0; bus.in_q = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_not_armed", int'(bus.is_armed), 0);
        pulse_arm();
        check("armed_after_arm", int'(bus.is_armed), 1);

        // Loopback: exact sync word then random payload
        load_bits(-1, -1, -1);
        expect_burst(NB, -1);
        run_burst(NB, -1, 1'b0, 1'b0);
        check("loopback_drain", q.size(), 0);
        check("loopback_idle", int'(bus.is_armed), 0);

        // Two sync bits wrong: still accepted
        load_bits(3, 17, -1);
        pulse_arm();
        expect_burst(NB, -1);
        run_burst(NB, -1, 1'b0, 1'b0);
        check("tol2_drain", q.size(), 0);

        // Three sync bits wrong: hunt times out
        load_bits(3, 10, 17);
        pulse_arm();
        expect_burst(NB, -1);
        run_burst(NB, -1, 1'b0, 1'b0);
        check("tol3_drain", q.size(), 0);

        // Envelope drops after 40 payload bits
        load_bits(-1, -1, -1);
        pulse_arm();
        expect_burst(NB, 26 + 40);
        run_burst(NB, 26 + 40, 1'b0, 1'b0);
        check("drop_drain", q.size(), 0);
        check("drop_idle", int'(bus.is_armed), 0);

        // No arm: whole burst must be silent
        load_bits(-1, -1, -1);
        run_burst(NB, -1, 1'b0, 1'b0);
        check("unarmed_idle", int'(bus.is_armed), 0);

        // Arm while the envelope is already high: wait for the next rising edge
        for (int i = 0; i < 8; i++) send(cos16(i), cos16(i - 4), 1'b1, 1'b0);
        pulse_arm();
        check("armed_while_high", int'(bus.is_armed), 1);
        for (int i = 8; i < 48; i++) send(cos16(i), cos16(i - 4), 1'b1, 1'b0);
        check("armed_hold_high", int'(bus.is_armed), 1);
        expect_burst(NB, -1);
        run_burst(NB, -1, 1'b0, 1'b0);
        check("rearm_drain", q.size(), 0);

        // Full-scale samples: largest cross products, both rotation senses
        load_bits(-1, -1, -1);
        pulse_arm();
        expect_burst(NB, -1);
        run_burst(NB, -1, 1'b1, 1'b0);
        check("corner_drain", q.size(), 0);

        // Reset in the middle of the payload
        load_bits(-1, -1, -1);
        pulse_arm();
        expect_burst(39, -1);
        run_burst(40, -1, 1'b1, 1'b1);
        check("midreset_drain", q.size(), 0);
        check("midreset_outs", outs(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
